// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t INIT     = 2'd0;
  localparam state_t RUN      = 2'd1;
  localparam state_t MEM_WAIT = 2'd2;

  // x0 is hardwired zero, so it never creates a true dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic sat;
  assign sat = &cnt;

  // Count one per qualifying cycle; hold once saturated
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)         cnt <= '0;
    else if (inc && !sat) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, redirect flush, load-use
// bubble, with saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     state, state_nxt;
  logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0] fl;   // {if_id, id_ex, ex_mem}
  logic       load_use, mem_wait, active;
  logic       stall_inc, flush_inc;

  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign active   = (state == RUN) || (state == MEM_WAIT);

  // An ack in the same cycle as the request (or ending a wait) frees the pipe
  assign mem_wait = active && !dmem_ack &&
                    ((state == MEM_WAIT) || dmem_req);

  // Hazard resolution, priority memory wait > redirect > load-use
  always_comb begin
    en        = '1;
    fl        = '0;
    state_nxt = state;
    flush_inc = 1'b0;
    if (!active) begin
      fl        = '1;
      state_nxt = RUN;
    end else if (mem_wait) begin
      en        = '0;
      state_nxt = MEM_WAIT;
    end else if (mem_redirect) begin
      fl        = '1;
      flush_inc = 1'b1;
      state_nxt = RUN;
    end else if (load_use) begin
      en        = 5'b00111;
      fl        = 3'b010;
      state_nxt = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  assign stall_inc = active && !en[4];

  assign {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = en;
  assign {flush_if_id, flush_id_ex, flush_ex_mem}          = fl;

  // State register; reset abandons any outstanding memory wait
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= INIT;
    else         state <= state_nxt;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (stall_inc),
    .cnt    (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (flush_inc),
    .cnt    (flush_cnt)
  );

endmodule
